ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Drives the configuration-chain (ccff) protocol from the programming side.
- Accepts bitstream words from a host over a valid/ready stream and serialises them onto ccff_head, one bit per enabled prog_clk cycle, for exactly CHAIN_LEN bits.
- Emits a clock-enable that gates prog_clk to the chain flops.
- Sits between the host/bitstream interface and the head of a tile's ccff chain.
- Optionally deserialises the bits leaving ccff_tail, so the previous configuration can be read back.

Parameters:
- WORD_W, 16, host word width in bits (>=2).
- CHAIN_LEN, 24, number of ccff flops in the target chain (>=1).
- CNT_W, $clog2(CHAIN_LEN+1), width of the bit counter (derived; not overridden).

Ports:
- prog_clk  in  1  programming clock; all state on rising edge.
- prog_rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a load.
- abort  in  1  terminates a load in progress.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader accepts s_data this cycle.
- s_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- ccff_head  out  1  serial data to chain head (registered).
- ccff_clk_en  out  1  chain shift enable for the external clock gate (registered); the chain samples ccff_head on an edge where this is 1.
- ccff_tail  in  1  serial data returning from the chain tail.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when CHAIN_LEN bits have been shifted.

Behaviour:
- Reset (asynchronous, prog_rst_n=0): state IDLE; s_ready, ccff_head, ccff_clk_en, busy and done are all 0; counters are 0.
- Bit counter rem counts the chain bits still to shift.
- States: IDLE, FETCH, SHIFT, FINISH.
- IDLE
  - start=1 -> FETCH; busy=1 from the next cycle; rem=CHAIN_LEN.
  - start is ignored in all other states.
- FETCH
  - s_ready=1.
  - On s_valid&&s_ready: capture s_data into the shift register; nbits=min(WORD_W, rem); go to SHIFT.
  - s_valid=0 holds FETCH with ccff_clk_en=0, so the chain is frozen and no bit is lost or duplicated.
- SHIFT
  - Each cycle: ccff_head<=sreg[0]; ccff_clk_en<=1; sreg>>=1; rem--, nbits--.
  - When nbits reaches 0: if rem=0 go to FINISH, else go to FETCH.
- Latency and throughput:
  - The first ccff_clk_en=1 occurs 2 cycles after word acceptance.
  - Sustained rate is one bit per cycle within a word, plus one FETCH cycle per word.
- Partial last word: only the low (CHAIN_LEN mod WORD_W) bits are used; the upper bits are discarded. No extra word is requested.
- FINISH
  - ccff_clk_en<=0 (the last shift edge has already occurred).
  - done=1 for one cycle; busy=0; return to IDLE.
- Abort
  - abort=1 in any non-IDLE state -> IDLE next cycle: ccff_clk_en=0, s_ready=0, busy=0, done not asserted.
  - The chain holds a partial shift; the host must reload.
  - abort has priority over word acceptance in the same cycle, so that word is not consumed.
- Simultaneous start and abort in IDLE: start is ignored.
- Reset mid-operation: outputs go to their reset values immediately and asynchronously; ccff_clk_en drops without waiting for a clock edge.
- Invariant: the number of ccff_clk_en=1 cycles per completed load is exactly CHAIN_LEN.

Optional Feature:
- Macro: CCFF_READBACK_EN.
- With the macro:
  - Adds outputs m_valid (1), m_data (WORD_W) and input m_ready (1).
  - On every edge where ccff_clk_en=1, ccff_tail (its pre-edge value, i.e. the bit being shifted out) is shifted into rb_sreg at position rb_cnt, LSB first.
  - m_valid asserts when WORD_W bits are collected, or on the final chain bit (upper bits zero-filled).
  - m_data holds until m_valid&&m_ready.
  - If a new readback word would complete while m_valid=1 and m_ready=0, SHIFT stalls (ccff_clk_en=0) until the word is accepted.
  - done asserts only after the last readback word is accepted.
  - Reset values: m_valid=0, m_data=0.
- Without the macro: these ports and their logic do not exist; ccff_tail is unused.

Decomposition:
- Shared package ccff_pkg holds:
  - the state enum (IDLE/FETCH/SHIFT/FINISH);
  - the localparam for the ccff_head reset value;
  - a count-width helper function.
- One natural sub-module: ccff_readback_deser (the tail deserialiser with its output handshake), instantiated only under CCFF_READBACK_EN.

Test Plan:
- Full load: WORD_W=16, CHAIN_LEN=24; words 0xA5C3 then 0x00F0 -> 24 ccff_clk_en pulses; head sequence is the LSB-first bits of 0xA5C3, then 0x00F0 bits 0..7; a model chain equals 0xF0A5C3 (bit0 deepest); done pulses once; exactly 2 words are accepted.
- Host stall: s_valid withheld 5 cycles between words -> ccff_clk_en=0 throughout the gap; chain content is identical to the full-load case.
- Abort: assert abort after 10 shifted bits -> next cycle busy=0, ccff_clk_en=0, no done; a following start with a full stream loads correctly.
- Async reset: pull prog_rst_n low during SHIFT, off-edge -> ccff_clk_en, busy, s_ready and ccff_head are 0 before the next edge.
- Start ignored: pulse start while busy -> no effect on count or words consumed.
- Readback (CCFF_READBACK_EN): preload the model chain with 0x123456, load 0xFFFF and 0x00FF -> m_data 0x3456 then 0x0012; holding m_ready=0 stalls ccff_clk_en; done comes after the second m_ready.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and helpers for the ccff chain loader.
// Optional tail readback is enabled with CCFF_READBACK_EN.
package ccff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_FINISH
    } state_e;

    localparam logic HEAD_RST = 1'b0;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Valid/ready word stream used for host bitstream input and readback output.
interface ccff_stream_if #(
    parameter int WORD_W = 16
);
    logic              valid;
    logic              ready;
    logic [WORD_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/ccff_chain_loader_readback.sv
// Deserialises bits leaving the chain tail into words (CCFF_READBACK_EN).
// The last chain bit closes a partial word with upper bits zero-filled.
module ccff_readback_deser
    import ccff_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int CHAIN_LEN = 24
) (
    input  logic prog_clk,
    input  logic prog_rst_n,
    input  logic i_clear,
    input  logic i_shift,
    input  logic i_bit,
    ccff_stream_if.master m,
    output logic o_fin
);
    localparam int CNT_W = cnt_w(CHAIN_LEN);
    localparam int NB_W  = cnt_w(WORD_W);

    logic [WORD_W-1:0] r_sreg;
    logic [WORD_W-1:0] r_data;
    logic [WORD_W-1:0] w_word;
    logic [NB_W-1:0]   r_cnt;
    logic [CNT_W-1:0]  r_total;
    logic              r_valid;
    logic              w_last;

    assign w_word = r_sreg | ({{(WORD_W-1){1'b0}}, i_bit} << r_cnt);
    assign w_last = (r_cnt == NB_W'(WORD_W - 1))
                 || (r_total == CNT_W'(CHAIN_LEN - 1));

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_sreg  <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_total <= '0;
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_sreg  <= '0;
            r_cnt   <= '0;
            r_total <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_valid && m.ready)
                r_valid <= 1'b0;
            if (i_shift) begin
                r_total <= r_total + CNT_W'(1);
                if (w_last) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                    r_sreg  <= '0;
                    r_cnt   <= '0;
                end else begin
                    r_sreg <= w_word;
                    r_cnt  <= r_cnt + NB_W'(1);
                end
            end
        end
    end

    assign m.valid = r_valid;
    assign m.data  = r_data;
    assign o_fin   = (r_total == CNT_W'(CHAIN_LEN)) && !r_valid;

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words onto a ccff chain head with a gated shift enable.
// Define CCFF_READBACK_EN to add the tail readback stream (port m).
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int CHAIN_LEN = 24
) (
    input  logic prog_clk,
    input  logic prog_rst_n,
    input  logic start,
    input  logic abort,
    ccff_stream_if.slave s,
    output logic ccff_head,
    output logic ccff_clk_en,
    input  logic ccff_tail,
`ifdef CCFF_READBACK_EN
    ccff_stream_if.master m,
`endif
    output logic busy,
    output logic done
);
    localparam int CNT_W = cnt_w(CHAIN_LEN);
    localparam int NB_W  = cnt_w(WORD_W);

    state_e            r_state;
    state_e            w_nstate;
    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  w_rem;
    logic [NB_W-1:0]   r_nbits;
    logic [NB_W-1:0]   w_nbits;
    logic [WORD_W-1:0] r_sreg;
    logic [WORD_W-1:0] w_sreg;
    logic              r_head;
    logic              w_head;
    logic              r_clk_en;
    logic              w_clk_en;
    logic              w_ready;
    logic              w_busy;
    logic              w_done;
    logic              w_stall;
    logic              w_rb_fin;

`ifdef CCFF_READBACK_EN
    logic w_clear;

    assign w_clear = (r_state == ST_IDLE) ? (start && !abort) : abort;
    // Readback words align with host words, so only a word's last bit can complete one.
    assign w_stall = (r_nbits == NB_W'(1)) && m.valid && !m.ready;

    ccff_readback_deser #(
        .WORD_W    (WORD_W),
        .CHAIN_LEN (CHAIN_LEN)
    ) u_rb (
        .prog_clk   (prog_clk),
        .prog_rst_n (prog_rst_n),
        .i_clear    (w_clear),
        .i_shift    (r_clk_en),
        .i_bit      (ccff_tail),
        .m          (m),
        .o_fin      (w_rb_fin)
    );
`else
    logic w_unused_tail;

    assign w_unused_tail = ccff_tail;
    assign w_stall       = 1'b0;
    assign w_rb_fin      = 1'b1;
`endif

    always_ff @(posedge prog_clk or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state  <= ST_IDLE;
            r_rem    <= '0;
            r_nbits  <= '0;
            r_sreg   <= '0;
            r_head   <= HEAD_RST;
            r_clk_en <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_rem    <= w_rem;
            r_nbits  <= w_nbits;
            r_sreg   <= w_sreg;
            r_head   <= w_head;
            r_clk_en <= w_clk_en;
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_rem    = r_rem;
        w_nbits  = r_nbits;
        w_sreg   = r_sreg;
        w_head   = r_head;
        w_clk_en = 1'b0;
        w_ready  = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_nstate = ST_FETCH;
                    w_rem    = CNT_W'(CHAIN_LEN);
                end
            end
            ST_FETCH: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_nstate = ST_IDLE;
                end else begin
                    w_ready = 1'b1;
                    if (s.valid) begin
                        w_sreg   = s.data;
                        w_nstate = ST_SHIFT;
                        if (32'(r_rem) >= WORD_W)
                            w_nbits = NB_W'(WORD_W);
                        else
                            w_nbits = NB_W'(r_rem);
                    end
                end
            end
            ST_SHIFT: begin
                w_busy = 1'b1;
                if (abort) begin
                    w_nstate = ST_IDLE;
                end else if (!w_stall) begin
                    w_head   = r_sreg[0];
                    w_clk_en = 1'b1;
                    w_sreg   = r_sreg >> 1;
                    w_rem    = r_rem - CNT_W'(1);
                    w_nbits  = r_nbits - NB_W'(1);
                    if (r_nbits == NB_W'(1))
                        w_nstate = (r_rem == CNT_W'(1)) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH: begin
                if (abort) begin
                    w_nstate = ST_IDLE;
                end else if (w_rb_fin) begin
                    w_done   = 1'b1;
                    w_nstate = ST_IDLE;
                end
            end
        endcase
    end

    assign s.ready     = w_ready;
    assign ccff_head   = r_head;
    assign ccff_clk_en = r_clk_en;
    assign busy        = w_busy;
    assign done        = w_done;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboarded bench for ccff_chain_loader with a behavioural chain model.
// Readback checks are compiled in with CCFF_READBACK_EN.
module tb_ccff_chain_loader;
    localparam int W  = 16;
    localparam int CL = 24;
    localparam int NW = (CL + W - 1) / W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic ccff_head, ccff_clk_en, ccff_tail, busy, done;

    ccff_stream_if #(.WORD_W(W)) s_if ();
`ifdef CCFF_READBACK_EN
    ccff_stream_if #(.WORD_W(W)) m_if ();
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int accepted = 0;
    int model_rem = 0;
    bit done_pend = 1'b0;
    bit rb_hold = 1'b0;

    logic [CL-1:0] chain;
    logic          pre_req = 1'b0;
    logic [CL-1:0] pre_val = '0;

    bit            bit_q[$];
    logic [CL-1:0] chain_q[$];
    logic [W-1:0]  rb_q[$];

    always #5 clk = ~clk;

    ccff_chain_loader #(.WORD_W(W), .CHAIN_LEN(CL)) dut (
        .prog_clk    (clk),
        .prog_rst_n  (rst_n),
        .start       (start),
        .abort       (abort),
        .s           (s_if),
        .ccff_head   (ccff_head),
        .ccff_clk_en (ccff_clk_en),
        .ccff_tail   (ccff_tail),
`ifdef CCFF_READBACK_EN
        .m           (m_if),
`endif
        .busy        (busy),
        .done        (done)
    );

    // Target chain: head enters at the top, bit 0 is deepest and feeds the tail.
    always @(posedge clk) begin
        if (pre_req)
            chain <= pre_val;
        else if (ccff_clk_en)
            chain <= {ccff_head, chain[CL-1:1]};
    end
    assign ccff_tail = chain[0];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (done_pend) begin
                done_pend = 1'b0;
                chk("done_expected", 32'(chain_q.size() != 0), 1);
                if (chain_q.size() != 0)
                    chk("chain", 32'(chain), 32'(chain_q.pop_front()));
            end
            if (ccff_clk_en) begin
                pulses++;
                chk("shift_expected", 32'(bit_q.size() != 0), 1);
                if (bit_q.size() != 0)
                    chk("head_bit", 32'(ccff_head), 32'(bit_q.pop_front()));
            end
            if (s_if.valid && s_if.ready)
                accepted++;
`ifdef CCFF_READBACK_EN
            if (m_if.valid && m_if.ready) begin
                chk("rb_expected", 32'(rb_q.size() != 0), 1);
                if (rb_q.size() != 0)
                    chk("rb_word", 32'(m_if.data), 32'(rb_q.pop_front()));
            end
`endif
            if (done) begin
                chk("pulses", pulses, CL);
                chk("words", accepted, NW);
`ifdef CCFF_READBACK_EN
                chk("rb_left", rb_q.size(), 0);
`endif
                pulses    = 0;
                accepted  = 0;
                done_pend = 1'b1;
            end
        end
    end

`ifdef CCFF_READBACK_EN
    initial begin
        m_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_if.ready = rb_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end
`endif

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap);
        bit ok;
        int n;
        if (gap > 0) begin
            ok = 1'b0;
            for (int t = 0; t < 300; t++) begin
                @(negedge clk);
                if (s_if.ready) begin ok = 1'b1; break; end
            end
            chk("fetch_timeout", 32'(ok), 1);
            repeat (gap) begin
                @(negedge clk);
                chk("gap_clk_en", 32'(ccff_clk_en), 0);
            end
            @(posedge clk); #1;
        end
        s_if.valid = 1'b1;
        s_if.data  = w;
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (s_if.ready) begin
                n = (model_rem < W) ? model_rem : W;
                for (int i = 0; i < n; i++)
                    bit_q.push_back(w[i]);
                model_rem -= n;
                ok = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        s_if.valid = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input int gap, input bit poke, input bit lat);
        logic [2*W-1:0] cat;
        logic [2*W-1:0] pc;
        bit ok;
        cat = {w1, w0};
        chain_q.push_back(cat[CL-1:0]);
        pc = {{(2*W-CL){1'b0}}, chain};
`ifdef CCFF_READBACK_EN
        rb_q.push_back(pc[W-1:0]);
        rb_q.push_back(pc[2*W-1:W]);
`endif
        model_rem = CL;
        pulse_start();
        send_word(w0, 0);
        if (lat) begin
            chk("lat_cycle1", 32'(ccff_clk_en), 0);
            @(posedge clk); #1;
            chk("lat_cycle2", 32'(ccff_clk_en), 1);
        end
        if (poke) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        send_word(w1, gap);
        s_if.valid = 1'b1;
        s_if.data  = W'($urandom);
        ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        chk("done_timeout", 32'(ok), 1);
        @(posedge clk); #1;
        s_if.valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic flush_model();
        bit_q.delete();
        rb_q.delete();
        pulses    = 0;
        accepted  = 0;
        done_pend = 1'b0;
    endtask

    initial begin
        bit ok;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        #12;
        chk("rst_ready", 32'(s_if.ready), 0);
        chk("rst_head", 32'(ccff_head), 0);
        chk("rst_clk_en", 32'(ccff_clk_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
`ifdef CCFF_READBACK_EN
        chk("rst_m_valid", 32'(m_if.valid), 0);
        chk("rst_m_data", 32'(m_if.data), 0);
`endif
        pre_val = '0;
        pre_req = 1'b1;
        @(posedge clk); #1;
        pre_req = 1'b0;
        rst_n   = 1'b1;

        do_load(16'hA5C3, 16'h00F0, 0, 1'b0, 1'b1);
        do_load(16'hA5C3, 16'h00F0, 5, 1'b0, 1'b0);

        // Abort after 10 shifted bits.
        model_rem = CL;
        pulse_start();
        send_word(W'($urandom), 0);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk); #1;
            if (pulses >= 10) begin ok = 1'b1; break; end
        end
        chk("abort_reach", 32'(ok), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_clk_en", 32'(ccff_clk_en), 0);
        chk("abort_ready", 32'(s_if.ready), 0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
        end
        flush_model();
        do_load(W'($urandom), W'($urandom), 0, 1'b0, 1'b0);

        // Start together with abort in IDLE does nothing.
        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", 32'(busy), 0);
        chk("sa_ready", 32'(s_if.ready), 0);

        // Asynchronous reset in the middle of shifting.
        model_rem = CL;
        pulse_start();
        send_word(16'hFFFF, 0);
        repeat (4) @(posedge clk);
        #3;
        chk("pre_rst_clk_en", 32'(ccff_clk_en), 1);
        chk("pre_rst_head", 32'(ccff_head), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_clk_en", 32'(ccff_clk_en), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ready", 32'(s_if.ready), 0);
        chk("arst_head", 32'(ccff_head), 0);
        flush_model();
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_load(W'($urandom), W'($urandom), 0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++)
            do_load(W'($urandom), W'($urandom), $urandom_range(0, 3),
                    1'($urandom_range(0, 1)), 1'b0);

`ifdef CCFF_READBACK_EN
        pre_val = 24'h123456;
        pre_req = 1'b1;
        @(posedge clk); #1;
        pre_req = 1'b0;
        rb_hold = 1'b1;
        fork
            do_load(16'hFFFF, 16'h00FF, 0, 1'b0, 1'b0);
            begin
                bit vok;
                vok = 1'b0;
                for (int t = 0; t < 200; t++) begin
                    @(negedge clk);
                    if (m_if.valid) begin vok = 1'b1; break; end
                end
                chk("rb_first_valid", 32'(vok), 1);
                repeat (15) @(negedge clk);
                chk("rb_stall_clk_en", 32'(ccff_clk_en), 0);
                chk("rb_stall_busy", 32'(busy), 1);
                chk("rb_hold_data", 32'(m_if.data), 32'h3456);
                @(posedge clk); #1;
                rb_hold = 1'b0;
            end
        join
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
